// File: rtl/apb_slave_regfile_if.sv
// APB bus bundle between the bridge (master) and the register file (slave).
interface apb_slave_regfile_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  psel;
  logic                  penable;
  logic [ADDR_WIDTH-1:0] paddr;
  logic                  pwrite;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output psel, penable, paddr, pwrite, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, paddr, pwrite, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_slave_regfile.sv
// APB completer with a bank of 32-bit registers; the top register is a read-only
// count of error-free completed transfers. Wait states are fixed by WAIT_CYCLES.
module apb_slave_regfile #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input logic                i_pclk,
  input logic                i_preset,
  apb_slave_regfile_if.slave bus
);

  localparam int unsigned           IdxW      = $clog2(NUM_REGS);
  localparam logic [IdxW-1:0]       CntIdx    = IdxW'(NUM_REGS - 1);
  localparam logic [ADDR_WIDTH-1:0] AddrLimit = ADDR_WIDTH'(NUM_REGS * 4);

  typedef enum logic [0:0] {StIdle, StAccess} state_e;

  state_e                r_state;
  logic [IdxW-1:0]       r_idx;
  logic                  r_write;
  logic                  r_err;
  logic [3:0]            r_wait;
  logic [DATA_WIDTH-1:0] r_prdata;
  logic                  r_pready;
  logic                  r_pslverr;
  // Slot NUM_REGS-1 is the transfer counter; the error path keeps writes off it.
  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

  logic [IdxW-1:0] w_idx;
  logic            w_err;
  logic            w_setup;

  assign w_idx   = bus.paddr[2 +: IdxW];
  assign w_err   = (bus.paddr[1:0] != 2'b00) || (bus.paddr >= AddrLimit) ||
                   (bus.pwrite && (w_idx == CntIdx));
  assign w_setup = bus.psel && !bus.penable;

  // Transfer FSM: captures setup, counts wait states, commits on completion.
  always_ff @(posedge i_pclk) begin
    if (i_preset) begin
      r_state   <= StIdle;
      r_idx     <= '0;
      r_write   <= 1'b0;
      r_err     <= 1'b0;
      r_wait    <= '0;
      r_prdata  <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      unique case (r_state)
        StIdle: begin
          // A stray PENABLE without setup is simply ignored here.
          if (w_setup) begin
            r_idx     <= w_idx;
            r_write   <= bus.pwrite;
            r_err     <= w_err;
            r_wait    <= 4'(WAIT_CYCLES);
            r_prdata  <= (!bus.pwrite && !w_err) ? r_regs[w_idx] : '0;
            r_pslverr <= w_err;
            r_pready  <= (WAIT_CYCLES == 0);
            r_state   <= StAccess;
          end
        end
        StAccess: begin
          if (!bus.psel) begin
            // Abort: nothing committed.
            r_prdata  <= '0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_state   <= StIdle;
          end else if (bus.penable) begin
            if (r_pready) begin
              if (r_write && !r_err) begin
                r_regs[r_idx] <= bus.pwdata;
              end
              if (!r_err) begin
                r_regs[CntIdx] <= r_regs[CntIdx] + 1'b1;
              end
              r_prdata  <= '0;
              r_pready  <= 1'b0;
              r_pslverr <= 1'b0;
              r_state   <= StIdle;
            end else begin
              r_wait   <= r_wait - 4'd1;
              r_pready <= (r_wait == 4'd1);
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.prdata  = r_prdata;
  assign bus.pready  = r_pready;
  assign bus.pslverr = r_pslverr;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed bench: three register files with 0, 3 and 2 wait states share one
// set of bus drivers; PSEL/PENABLE are steered to the instance chosen by sel.
module tb_apb_slave_regfile;

  logic        clk;
  logic        r_preset;
  logic        r_psel;
  logic        r_penable;
  logic [31:0] r_paddr;
  logic        r_pwrite;
  logic [31:0] r_pwdata;
  int          sel;

  logic [31:0] w_prdata;
  logic        w_pready;
  logic        w_pslverr;

  int n_vec;
  int n_err;

  apb_slave_regfile_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if0 ();
  apb_slave_regfile_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if3 ();
  apb_slave_regfile_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if2 ();

  assign if0.psel    = r_psel && (sel == 0);
  assign if0.penable = r_penable && (sel == 0);
  assign if0.paddr   = r_paddr;
  assign if0.pwrite  = r_pwrite;
  assign if0.pwdata  = r_pwdata;
  assign if3.psel    = r_psel && (sel == 3);
  assign if3.penable = r_penable && (sel == 3);
  assign if3.paddr   = r_paddr;
  assign if3.pwrite  = r_pwrite;
  assign if3.pwdata  = r_pwdata;
  assign if2.psel    = r_psel && (sel == 2);
  assign if2.penable = r_penable && (sel == 2);
  assign if2.paddr   = r_paddr;
  assign if2.pwrite  = r_pwrite;
  assign if2.pwdata  = r_pwdata;

  apb_slave_regfile #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16), .WAIT_CYCLES(0)) u_dut0 (
    .i_pclk   (clk),
    .i_preset (r_preset),
    .bus      (if0)
  );
  apb_slave_regfile #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16), .WAIT_CYCLES(3)) u_dut3 (
    .i_pclk   (clk),
    .i_preset (r_preset),
    .bus      (if3)
  );
  apb_slave_regfile #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16), .WAIT_CYCLES(2)) u_dut2 (
    .i_pclk   (clk),
    .i_preset (r_preset),
    .bus      (if2)
  );

  always_comb begin
    w_prdata  = if0.prdata;
    w_pready  = if0.pready;
    w_pslverr = if0.pslverr;
    if (sel == 3) begin
      w_prdata  = if3.prdata;
      w_pready  = if3.pready;
      w_pslverr = if3.pslverr;
    end else if (sel == 2) begin
      w_prdata  = if2.prdata;
      w_pready  = if2.pready;
      w_pslverr = if2.pslverr;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transfer; returns response, number of PREADY-low ACCESS cycles and
  // whether PRDATA held steady from T1 through completion.
  task automatic apb_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int waits,
                          output logic stable);
    logic [31:0] first;
    logic        done;
    rdata  = 'x;
    err    = 1'bx;
    waits  = 0;
    stable = 1'b1;
    done   = 1'b0;
    r_psel    = 1'b1;
    r_penable = 1'b0;
    r_paddr   = addr;
    r_pwrite  = wr;
    r_pwdata  = wdata;
    tick();
    r_penable = 1'b1;
    first = w_prdata;
    for (int c = 0; c < 40 && !done; c++) begin
      if (w_prdata !== first) stable = 1'b0;
      if (w_pready === 1'b1) begin
        rdata = w_prdata;
        err   = w_pslverr;
        done  = 1'b1;
      end else begin
        waits++;
      end
      tick();
    end
    r_psel    = 1'b0;
    r_penable = 1'b0;
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL xfer_timeout addr=%h: PREADY never rose, required within 40 cycles", addr);
    end
  endtask

  task automatic pulse_reset();
    r_preset = 1'b1;
    r_psel = 1'b0;
    r_penable = 1'b0;
    repeat (2) tick();
    r_preset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    pulse_reset();
    for (int k = 0; k < 4; k++) begin
      if (k == 1) continue;
      sel = k;
      #1;
      n_vec++;
      if ({w_prdata, w_pready, w_pslverr} !== 34'd0) begin
        n_err++;
        $display("FAIL reset_outputs dut%0d: got prdata=%h pready=%b pslverr=%b, required all 0",
                 k, w_prdata, w_pready, w_pslverr);
      end
    end
    sel = 0;
    #1;
  endtask

  task automatic test_basic();
    logic [31:0] d;
    logic e, st;
    int w;
    sel = 0;
    apb_xfer(32'h08, 1'b1, 32'hDEADBEEF, d, e, w, st);
    n_vec++;
    if (w !== 0 || e !== 1'b0) begin
      n_err++;
      $display("FAIL basic_write: got waits=%0d err=%b, required 0/0", w, e);
    end
    apb_xfer(32'h08, 1'b0, 32'h0, d, e, w, st);
    n_vec++;
    if (d !== 32'hDEADBEEF || e !== 1'b0 || w !== 0) begin
      n_err++;
      $display("FAIL basic_read: got data=%h err=%b waits=%0d, required deadbeef/0/0", d, e, w);
    end
    apb_xfer(32'h3C, 1'b0, 32'h0, d, e, w, st);
    n_vec++;
    if (d !== 32'd2 || e !== 1'b0) begin
      n_err++;
      $display("FAIL basic_xfer_cnt: got %0d err=%b, required 2/0", d, e);
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] d;
    logic e, st;
    int w;
    sel = 3;
    apb_xfer(32'h04, 1'b1, 32'h12345678, d, e, w, st);
    n_vec++;
    if (w !== 3 || e !== 1'b0) begin
      n_err++;
      $display("FAIL wait_write: got waits=%0d err=%b, required 3/0", w, e);
    end
    apb_xfer(32'h04, 1'b0, 32'h0, d, e, w, st);
    n_vec++;
    if (w !== 3 || d !== 32'h12345678 || st !== 1'b1) begin
      n_err++;
      $display("FAIL wait_read: got waits=%0d data=%h stable=%b, required 3/12345678/1",
               w, d, st);
    end
  endtask

  task automatic test_errors();
    logic [31:0] d;
    logic e, st;
    int w;
    logic [31:0] bad_addr [3];
    bad_addr[0] = 32'h40;
    bad_addr[1] = 32'h06;
    bad_addr[2] = 32'h3C;
    sel = 0;
    for (int i = 0; i < 3; i++) begin
      apb_xfer(bad_addr[i], 1'b1, 32'hFFFF0000, d, e, w, st);
      n_vec++;
      if (e !== 1'b1 || w !== 0) begin
        n_err++;
        $display("FAIL err_write addr=%h: got err=%b waits=%0d, required 1/0", bad_addr[i], e, w);
      end
    end
    apb_xfer(32'h40, 1'b0, 32'h0, d, e, w, st);
    n_vec++;
    if (e !== 1'b1 || d !== 32'h0) begin
      n_err++;
      $display("FAIL err_read: got err=%b data=%h, required 1/00000000", e, d);
    end
    apb_xfer(32'h04, 1'b0, 32'h0, d, e, w, st);
    n_vec++;
    if (d !== 32'h0 || e !== 1'b0) begin
      n_err++;
      $display("FAIL err_reg04_unchanged: got %h err=%b, required 00000000/0", d, e);
    end
    apb_xfer(32'h08, 1'b0, 32'h0, d, e, w, st);
    n_vec++;
    if (d !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL err_reg08_unchanged: got %h, required deadbeef", d);
    end
    apb_xfer(32'h3C, 1'b0, 32'h0, d, e, w, st);
    n_vec++;
    if (d !== 32'd5) begin
      n_err++;
      $display("FAIL err_xfer_cnt: got %0d, required 5", d);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic e, st;
    int w;
    pulse_reset();
    sel = 0;
    for (int i = 0; i < 15; i++) begin
      apb_xfer(32'(i * 4), 1'b1, 32'hA0000000 + 32'(i) * 32'h00010101, d, e, w, st);
    end
    for (int i = 0; i < 15; i++) begin
      apb_xfer(32'(i * 4), 1'b0, 32'h0, d, e, w, st);
      n_vec++;
      if (d !== 32'hA0000000 + 32'(i) * 32'h00010101 || e !== 1'b0) begin
        n_err++;
        $display("FAIL b2b_read idx=%0d: got %h err=%b, required %h/0",
                 i, d, e, 32'hA0000000 + 32'(i) * 32'h00010101);
      end
    end
    apb_xfer(32'h3C, 1'b0, 32'h0, d, e, w, st);
    n_vec++;
    if (d !== 32'd30) begin
      n_err++;
      $display("FAIL b2b_xfer_cnt: got %0d, required 30", d);
    end
  endtask

  task automatic test_abort();
    logic [31:0] d;
    logic e, st;
    int w;
    sel = 2;
    apb_xfer(32'h10, 1'b1, 32'h0BADF00D, d, e, w, st);
    r_psel    = 1'b1;
    r_penable = 1'b0;
    r_paddr   = 32'h10;
    r_pwrite  = 1'b1;
    r_pwdata  = 32'hA5A5A5A5;
    tick();
    r_penable = 1'b1;
    tick();
    r_psel    = 1'b0;
    r_penable = 1'b0;
    n_vec++;
    if (w_pready !== 1'b0) begin
      n_err++;
      $display("FAIL abort_t2_pready: got %b, required 0", w_pready);
    end
    tick();
    n_vec++;
    if (w_pready !== 1'b0) begin
      n_err++;
      $display("FAIL abort_after_pready: got %b, required 0", w_pready);
    end
    apb_xfer(32'h10, 1'b0, 32'h0, d, e, w, st);
    n_vec++;
    if (d !== 32'h0BADF00D) begin
      n_err++;
      $display("FAIL abort_reg10: got %h, required 0badf00d", d);
    end
    apb_xfer(32'h3C, 1'b0, 32'h0, d, e, w, st);
    n_vec++;
    if (d !== 32'd2) begin
      n_err++;
      $display("FAIL abort_xfer_cnt: got %0d, required 2", d);
    end
  endtask

  task automatic test_reset_mid_and_stray();
    logic [31:0] d;
    logic e, st;
    int w;
    sel = 0;
    r_psel    = 1'b1;
    r_penable = 1'b0;
    r_paddr   = 32'h0C;
    r_pwrite  = 1'b1;
    r_pwdata  = 32'h00000077;
    tick();
    r_penable = 1'b1;
    r_preset  = 1'b1;
    tick();
    r_preset  = 1'b0;
    r_psel    = 1'b0;
    r_penable = 1'b0;
    n_vec++;
    if ({w_prdata, w_pready, w_pslverr} !== 34'd0) begin
      n_err++;
      $display("FAIL midreset_outputs: got prdata=%h pready=%b pslverr=%b, required all 0",
               w_prdata, w_pready, w_pslverr);
    end
    tick();
    r_psel    = 1'b1;
    r_penable = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_vec++;
      if (w_pready !== 1'b0) begin
        n_err++;
        $display("FAIL stray_penable_pready cycle %0d: got %b, required 0", i, w_pready);
      end
    end
    r_psel    = 1'b0;
    r_penable = 1'b0;
    tick();
    apb_xfer(32'h08, 1'b0, 32'h0, d, e, w, st);
    n_vec++;
    if (d !== 32'h0 || w !== 0) begin
      n_err++;
      $display("FAIL midreset_reg08: got %h waits=%0d, required 00000000/0", d, w);
    end
    apb_xfer(32'h0C, 1'b0, 32'h0, d, e, w, st);
    n_vec++;
    if (d !== 32'h0) begin
      n_err++;
      $display("FAIL midreset_reg0c: got %h, required 00000000", d);
    end
    apb_xfer(32'h3C, 1'b0, 32'h0, d, e, w, st);
    n_vec++;
    if (d !== 32'd2) begin
      n_err++;
      $display("FAIL midreset_xfer_cnt: got %0d, required 2", d);
    end
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    sel       = 0;
    r_preset  = 1'b1;
    r_psel    = 1'b0;
    r_penable = 1'b0;
    r_paddr   = '0;
    r_pwrite  = 1'b0;
    r_pwdata  = '0;
    test_reset();
    test_basic();
    test_wait_states();
    test_errors();
    test_back_to_back();
    test_abort();
    test_reset_mid_and_stray();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/apb_slave_regfile.md
# apb_slave_regfile

APB completer (slave) holding a small bank of memory-mapped 32-bit registers. It sits on the APB side of the AHB-to-APB bridge and answers the bridge's PSEL/PENABLE transfers with PREADY, PRDATA and PSLVERR. The number of wait states is programmable. The top register is a read-only count of completed transfers, which the bench uses to check bridge traffic end to end.

## Interface
- ADDR_WIDTH, 32, PADDR width
- DATA_WIDTH, 32, PWDATA/PRDATA width
- NUM_REGS, 16, register count; power of two, at least 2
- WAIT_CYCLES, 0, wait states per transfer (PREADY low cycles in ACCESS); 0 to 15

Clock and reset: one clock; reset is synchronous and active-high.

- PCLK  in  1  clock; all logic on the rising edge
- PRESET  in  1  synchronous active-high reset
- PSEL  in  1  slave select
- PENABLE  in  1  access phase
- PADDR  in  ADDR_WIDTH  byte address
- PWRITE  in  1  1 = write, 0 = read
- PWDATA  in  DATA_WIDTH  write data
- PRDATA  out  DATA_WIDTH  read data; registered
- PREADY  out  1  transfer completes this cycle; registered
- PSLVERR  out  1  error response; valid only while PREADY = 1; registered

## Operation
- Reset values: PRDATA = 0, PREADY = 0, PSLVERR = 0, all registers = 0, state = IDLE, wait counter = 0.
- Address decode:
  - idx = PADDR[2 +: log2(NUM_REGS)].
  - PADDR is valid only if PADDR[1:0] = 0 and PADDR < NUM_REGS*4.
- Register map:
  - idx 0 to NUM_REGS-2 are read/write.
  - idx NUM_REGS-1 is XFER_CNT, read-only. It is a DATA_WIDTH counter of transfers completed with PSLVERR = 0 and wraps to 0.
- Error (PSLVERR = 1) on:
  - an invalid address, or
  - a write to XFER_CNT.
  - An erroring transfer writes nothing, returns PRDATA = 0 and does not increment XFER_CNT.
- FSM has two states:
  - IDLE:
    - Setup is detected as PSEL=1 and PENABLE=0.
    - On setup: latch idx, PWRITE and the error flag. Load the wait counter with WAIT_CYCLES.
    - For a read: PRDATA <= reg[idx], or 0 on error.
    - PSLVERR <= error. PREADY <= (WAIT_CYCLES == 0).
    - Go to ACCESS.
  - ACCESS:
    - If PSEL=1, PENABLE=1 and PREADY=0: decrement the counter; PREADY <= (counter == 1).
    - Completion occurs when PSEL=1, PENABLE=1 and PREADY=1. At completion:
      - a write without error stores PWDATA (sampled at completion) into reg[idx];
      - XFER_CNT increments if there is no error;
      - PREADY, PSLVERR and PRDATA go to 0;
      - the next state is IDLE.
    - If PSEL=0 (abort): no write, no count; clear the outputs and go to IDLE.
- PENABLE=1 while in IDLE (no setup phase) is a protocol violation. It is ignored: PREADY stays 0 and no state change occurs.
- A new setup in the cycle immediately after a completion is accepted normally (back-to-back transfers).
- PRESET asserted mid-transfer: the next edge applies the reset values. Any write in flight is lost.

## Timing
- The setup cycle is T0. The first ACCESS cycle is T1.
- PREADY rises at T1 + WAIT_CYCLES and stays high for exactly 1 cycle.
- With WAIT_CYCLES = 0, every transfer takes 2 cycles. PENABLE is therefore never high for more than 1 cycle, as the bridge requires.
- PRDATA and PSLVERR are stable from T1 through completion. PRDATA returns the register value as of T0.
- Written data is visible to a read whose setup is at or after the completion edge + 1.
- XFER_CNT reflects a completion from the edge after that completion.
- No combinational paths from any input to any output.

## Test plan
- Reset, then write 0xDEADBEEF to 0x08, then read 0x08 (WAIT_CYCLES=0) -> PREADY high at T1 of each transfer; read PRDATA = 0xDEADBEEF, PSLVERR = 0; XFER_CNT (read at 0x3C) = 2.
- WAIT_CYCLES=3, read 0x04 after writing 0x12345678 -> PREADY low for T1 to T3 and high at T4; PRDATA = 0x12345678 during T1 to T4.
- Write 0x40 (out of range), write 0x06 (misaligned), write 0x3C (XFER_CNT) -> PSLVERR = 1 with PREADY on each; registers are unchanged; XFER_CNT unchanged.
- Back-to-back writes to 0x00 to 0x38 (15 regs), then reads -> each read returns its written value; XFER_CNT = 30.
- Abort: WAIT_CYCLES=2, PSEL drops at T2 of a write of 0xA5A5A5A5 to 0x10 -> reg 0x10 is unchanged, XFER_CNT is unchanged, PREADY = 0.
- PRESET asserted at T1 of a write; PENABLE high without setup -> all outputs and registers are 0 after reset; a stray PENABLE gives PREADY = 0 and no state change.
